// File: rtl/apb_slave_regs.sv
// APB4 slave with a 32-byte window of eight 32-bit read/write registers.
// A programmable number of wait states (wait_cfg) stretches every access
// phase; address, control and data are taken from the bus in the access
// phase itself, so the master must hold them stable until PREADY.
//
// Handshake: a transfer starts with a setup cycle (PSELx=1, PENABLE=0)
// followed by access cycles (PSELx=1, PENABLE=1). The transfer completes
// in the access cycle where PREADY=1; PRDATA/PSLVERR are valid only then.
// Dropping PSELx during an access phase abandons the transfer.
module apb_slave_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         PCLK,
  input  logic         PRESETn,
  input  logic         PSELx,
  input  logic         PENABLE,
  input  logic [31:0]  PADDR,
  input  logic [2:0]   PPROT,
  input  logic         PWRITE,
  input  logic [31:0]  PWDATA,
  input  logic [3:0]   PSTRB,
  output logic         PREADY,
  output logic [31:0]  PRDATA,
  output logic         PSLVERR,
  input  logic [3:0]   wait_cfg,
  output logic [255:0] reg_out
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] regs [8];

  logic        hit;
  logic [2:0]  idx;
  logic        err;
  logic        access_done;
  logic        no_setup;
  logic        wr_commit;

  // Only the privileged bit of PPROT matters here.
  logic unused_ok;
  assign unused_ok = &{1'b0, PPROT[2:1]};

  // Address decode and error classification from the live access-phase bus.
  always_comb begin
    hit = (PADDR[31:5] == BASE_ADDR[31:5]);
    idx = PADDR[4:2];
    err = !hit
        || (PADDR[1:0] != 2'b00)
        || (PWRITE && (idx == 3'd7) && !PPROT[0])
        || (!PWRITE && (PSTRB != 4'h0));
  end

  // Completion and response generation; all responses are forced low in reset.
  always_comb begin
    access_done = PRESETn && (state == ACCESS) && PSELx && PENABLE && (cnt == 4'd0);
    no_setup    = PRESETn && (state == IDLE) && PSELx && PENABLE;
    PREADY      = access_done || no_setup;
    PSLVERR     = (access_done && err) || no_setup;
    wr_commit   = access_done && PWRITE && !err;
    PRDATA      = 32'h0;
    if (access_done && !PWRITE && !err) begin
      PRDATA = regs[idx];
    end
  end

  // Transfer FSM: setup loads the wait counter, access phase counts it down.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (PSELx && !PENABLE) begin
            state <= ACCESS;
            cnt   <= wait_cfg;
          end
        end
        ACCESS: begin
          if (!PSELx) begin
            // Master abandoned the transfer.
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (!PENABLE) begin
            // A fresh setup cycle restarts the transfer.
            cnt <= wait_cfg;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // Register file: byte-lane write on the completing cycle of a good write.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wr_commit) begin
      for (int n = 0; n < 4; n++) begin
        if (PSTRB[n]) begin
          regs[idx][8*n +: 8] <= PWDATA[8*n +: 8];
        end
      end
    end
  end

  // Flatten the register file, R0 in the least significant word.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      reg_out[32*i +: 32] = regs[i];
    end
  end

endmodule
